// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared processor constants and fetch state encoding
// Contents:
//   PC_WIDTH, INSTR_WIDTH : datapath widths shared by fetch and the IF/ID register
//   NOP_INSTR             : bubble encoding loaded by IF/ID and ID/EX on reset or flush
//   fetch_state_t         : FETCH / HOLD / DRAIN
package instruction_fetch_unit_pkg;

    localparam int PC_WIDTH    = 8;
    localparam int INSTR_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'hF800_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buffer.sv
// rtl/fetch_hold_buffer.sv - one-entry buffer for an instruction fetched while stalled
// Ports:
//   clk, rst               : clock, asynchronous active-low reset
//   load                   : capture load_pc/load_instr and mark full
//   clear                  : drop the entry (wins over load)
//   load_pc, load_instr    : incremented PC and instruction to park
//   hold_pc, hold_instr    : parked values
//   full                   : an entry is parked
module fetch_hold_buffer #(
    parameter int PC_WIDTH    = instruction_fetch_unit_pkg::PC_WIDTH,
    parameter int INSTR_WIDTH = instruction_fetch_unit_pkg::INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   clear,
    input  logic [PC_WIDTH-1:0]    load_pc,
    input  logic [INSTR_WIDTH-1:0] load_instr,
    output logic [PC_WIDTH-1:0]    hold_pc,
    output logic [INSTR_WIDTH-1:0] hold_instr,
    output logic                   full
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_pc    <= '0;
            hold_instr <= '0;
            full       <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            hold_pc    <= load_pc;
            hold_instr <= load_instr;
            full       <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner and instruction fetch front end feeding IF/ID
// Ports:
//   clk, rst                      : clock, asynchronous active-low reset
//   stall                         : hazard-unit freeze, outputs hold
//   branch_taken, branch_target   : single-cycle redirect request and new fetch address
//   imem_req, imem_addr           : fetch request (decoded from state and pc)
//   imem_ack, imem_rdata          : fetch completion and instruction
//   if_pc, if_instruction         : fetch address + 1 and instruction (or NOP_INSTR) to IF/ID
//   if_valid                      : if_instruction is a real fetched instruction
//   if_flush                      : one-cycle flush pulse per branch_taken cycle
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                     PC_WIDTH    = instruction_fetch_unit_pkg::PC_WIDTH,
    parameter int                     INSTR_WIDTH = instruction_fetch_unit_pkg::INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = instruction_fetch_unit_pkg::NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [PC_WIDTH-1:0]    if_pc,
    output logic [INSTR_WIDTH-1:0] if_instruction,
    output logic                   if_valid,
    output logic                   if_flush
);

    fetch_state_t          state;
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   pc_inc;
    logic [PC_WIDTH-1:0]   drain_addr;
    logic                  started;
    logic                  accept;

    logic                   buf_load;
    logic                   buf_clear;
    logic [PC_WIDTH-1:0]    buf_pc;
    logic [INSTR_WIDTH-1:0] buf_instr;
    logic                   buf_full;

    // started keeps imem_req low for the first cycle after reset release, so a
    // stale ack from a transfer abandoned by reset can never be accepted.
    assign imem_req  = started && (state != HOLD);
    // During DRAIN pc already holds the redirect target; the outstanding
    // request must keep presenting its original address.
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;
    assign accept    = imem_req && imem_ack;
    assign pc_inc    = pc + PC_WIDTH'(1);

    assign buf_load  = !branch_taken && (state == FETCH) && accept && stall;
    assign buf_clear = branch_taken || ((state == HOLD) && !stall);

    fetch_hold_buffer #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_hold_buffer (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_pc    (pc_inc),
        .load_instr (imem_rdata),
        .hold_pc    (buf_pc),
        .hold_instr (buf_instr),
        .full       (buf_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            drain_addr     <= '0;
            started        <= 1'b0;
            if_pc          <= '0;
            if_instruction <= NOP_INSTR;
            if_valid       <= 1'b0;
            if_flush       <= 1'b0;
        end else begin
            started  <= 1'b1;
            if_flush <= branch_taken;
            if (branch_taken) begin
                // Redirect wins over stall and drops any same-cycle or parked data.
                pc             <= branch_target;
                drain_addr     <= imem_addr;
                if_pc          <= '0;
                if_instruction <= NOP_INSTR;
                if_valid       <= 1'b0;
                state          <= (imem_req && !imem_ack) ? DRAIN : FETCH;
            end else begin
                case (state)
                    FETCH: begin
                        if (accept) begin
                            pc <= pc_inc;
                            if (stall) begin
                                state <= HOLD;
                            end else begin
                                if_pc          <= pc_inc;
                                if_instruction <= imem_rdata;
                                if_valid       <= 1'b1;
                            end
                        end else if (!stall) begin
                            if_pc          <= '0;
                            if_instruction <= NOP_INSTR;
                            if_valid       <= 1'b0;
                        end
                    end
                    HOLD: begin
                        if (!stall) begin
                            state          <= FETCH;
                            if_pc          <= buf_full ? buf_pc : '0;
                            if_instruction <= buf_full ? buf_instr : NOP_INSTR;
                            if_valid       <= buf_full;
                        end
                    end
                    DRAIN: begin
                        // Outputs already carry the bubble from the redirect.
                        if (imem_ack) begin
                            state <= FETCH;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front end of the pipelined processor: owns the program counter, fetches 32-bit instructions from instruction memory over a req/ack handshake, and produces the `inPC`/`inInstruction`/`IF_Flush` triple consumed by the IF/ID pipeline register. It handles variable-latency memory, hazard-unit stalls and taken-branch redirects. The IF/ID register has no enable, so this block keeps its outputs stable during a stall.

## Interface
- `PC_WIDTH`, 8: PC and instruction-memory word-address width.
- `INSTR_WIDTH`, 32: instruction width.
- `RESET_PC`, 8'h00: first fetch address after reset.
- `NOP_INSTR`, 32'hF800_0000: bubble encoding. This is the value IF/ID loads on reset or flush.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-low reset.
- `stall`  in  1: hazard unit freezes fetch. Outputs hold their current values.
- `branch_taken`  in  1: redirect request from the branch resolution logic. Single-cycle qualifier.
- `branch_target`  in  PC_WIDTH: new fetch address. Valid while `branch_taken` is high.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  PC_WIDTH: fetch word address.
- `imem_ack`  in  1: `imem_rdata` is valid this cycle.
- `imem_rdata`  in  INSTR_WIDTH: fetched instruction.
- `if_pc`  out  PC_WIDTH: incremented PC (fetch address + 1) → IF/ID `inPC`.
- `if_instruction`  out  INSTR_WIDTH: fetched instruction or `NOP_INSTR` → IF/ID `inInstruction`.
- `if_valid`  out  1: `if_instruction` is a real fetched instruction.
- `if_flush`  out  1: one-cycle pulse → IF/ID `IF_Flush`.

## Operation
- Internal `pc` holds the next fetch address. Arithmetic is modulo 2^PC_WIDTH, so 8'hFF + 1 wraps to 8'h00.
- **Priority order:** `branch_taken` > `stall` > normal fetch.
- **FETCH state**
  - Drives `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_ack` with no stall: register `imem_rdata`, `if_pc`=`pc`+1 and `if_valid`=1. Set `pc`←`pc`+1 and stay in FETCH.
  - On `imem_ack` with `stall`: capture the data and `pc`+1 into the hold buffer, advance `pc`, and go to HOLD. Outputs are unchanged.
  - No ack and no stall: outputs become a bubble (`NOP_INSTR`, `if_pc`=0, `if_valid`=0).
  - No ack with `stall`: outputs hold.
- **HOLD state**
  - `imem_req`=0 and outputs hold.
  - When `stall` falls: present the buffered instruction with `if_valid`=1 and return to FETCH.
- **DRAIN state**
  - Entered when a redirect arrives while a request is outstanding (`imem_req`=1 without `imem_ack` that cycle).
  - Keeps `imem_req`=1 with the old `imem_addr` until `imem_ack`, discards that data, then goes to FETCH.
  - Outputs stay as a bubble. `stall` is ignored.
  - A second `branch_taken` during DRAIN updates `pc` and pulses `if_flush` again.
- **Redirect** (any state, `branch_taken`=1)
  - Sets `pc`←`branch_target` and discards any hold-buffer contents or same-cycle `imem_rdata`.
  - Next cycle: outputs = bubble and `if_flush`=1.
  - Next state is DRAIN if a request is outstanding, otherwise FETCH.
- **Handshake rule:** once `imem_req` rises, it and `imem_addr` stay constant until the `imem_ack` cycle, including through stalls and redirects. Ack may arrive in the same cycle as the request is raised.

## Timing
- **Reset values:** state=FETCH, `pc`=`RESET_PC`, `imem_req`=0, `if_pc`=0, `if_instruction`=`NOP_INSTR`, `if_valid`=0, `if_flush`=0.
- `imem_req` goes low asynchronously on reset assertion. It first rises in the cycle after reset is released.
- Reset mid-handshake abandons the transfer; a late ack after reset is ignored.
- All outputs are registered except `imem_req` and `imem_addr`, which decode from state and `pc`.
- **Latency:** one cycle from `imem_ack` to `if_instruction`. With zero-wait memory, throughput is one instruction per cycle.
- `if_flush` is high for exactly one cycle per `branch_taken` cycle.
- First valid instruction with zero-wait memory appears in the 2nd cycle after reset release.

## Structure
- Shared processor package holds `PC_WIDTH`, `INSTR_WIDTH`, the `NOP_INSTR` constant (also used by IF/ID and ID/EX flush logic) and the fetch state encoding FETCH/HOLD/DRAIN.
- One natural sub-module: `fetch_hold_buffer`, which holds {pc+1, instruction, full} during a stall.

## Test plan
- **Reset, zero-wait memory, no stall:** `if_instruction` sequence is mem[0], mem[1]…, with `if_pc`=1, 2, …, `if_valid`=1 from the 2nd cycle.
- **Ack 3 cycles late at addr 8'h05:** `imem_addr` stays at 05 for the 3 cycles, outputs are `NOP_INSTR`/`if_valid`=0, then mem[5] appears with `if_pc`=06.
- **Stall high 4 cycles at the ack of addr 8'h10:** outputs hold the previous instruction and `imem_req`=0 during the stall. After the stall, mem[0x10] appears with `if_pc`=0x11 and is not duplicated or lost.
- **`branch_taken`, target 8'h40, during an outstanding request to 8'h12 (ack 2 cycles later):**
  - `if_flush` pulses once.
  - `imem_addr` stays 12 until ack, and that data is dropped.
  - The next fetch is at 40, and mem[0x40] appears with `if_pc`=0x41.
- **`branch_taken` and `stall` together:** the redirect wins and `if_flush`=1. **PC wrap at 8'hFF:** `if_pc`=00 and the next fetch is at 00.
- **Reset asserted mid-DRAIN:** `imem_req` drops immediately, all outputs take reset values, and fetch restarts at `RESET_PC`.
